// File: rtl/aux_interface.sv
// Registered capture stage for the auxiliary input bus. It is a plain shift chain
// of SYNC_STAGES full-width registers, and it clears asynchronously on reset.
module aux_interface #(
    parameter int AUX_WIDTH   = 32,
    parameter int SYNC_STAGES = 1
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic [AUX_WIDTH-1:0] aux_in,
    output logic [AUX_WIDTH-1:0] aux_i
);

    // Out-of-range depths are clamped into 1..4 so that any instantiation still elaborates.
    localparam int STAGES = (SYNC_STAGES < 1) ? 1 :
                            (SYNC_STAGES > 4) ? 4 : SYNC_STAGES;

    logic [STAGES-1:0][AUX_WIDTH-1:0] stage_q;

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            stage_q <= '0;
        end else begin
            stage_q[0] <= aux_in;
            for (int k = 1; k < STAGES; k++) begin
                stage_q[k] <= stage_q[k-1];
            end
        end
    end

    // The output comes only from the last register, so aux_in has no combinational path to aux_i.
    assign aux_i = stage_q[STAGES-1];

endmodule

// File: tb/tb_aux_interface.sv
// Directed bench for aux_interface. It runs depth-1, depth-3 and clamped (9 -> 4) instances in parallel.
// Each instance has its own expected-value queue, which is pre-filled with zeros to model pipeline depth.
module tb_aux_interface;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic [31:0] aux_in;
    logic [31:0] aux_i_d1;
    logic [31:0] aux_i_d3;
    logic [31:0] aux_i_d4;

    logic [31:0] exp1_q[$];
    logic [31:0] exp3_q[$];
    logic [31:0] exp4_q[$];

    int tests_run = 0;
    int tests_failed = 0;

    always #5 sys_clk = ~sys_clk;

    aux_interface #(.AUX_WIDTH(32), .SYNC_STAGES(1)) dut_d1 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .aux_in(aux_in), .aux_i(aux_i_d1));
    aux_interface #(.AUX_WIDTH(32), .SYNC_STAGES(3)) dut_d3 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .aux_in(aux_in), .aux_i(aux_i_d3));
    aux_interface #(.AUX_WIDTH(32), .SYNC_STAGES(9)) dut_d4 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .aux_in(aux_in), .aux_i(aux_i_d4));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_d1"}, aux_i_d1, 32'h0);
        check({tag, "_d3"}, aux_i_d3, 32'h0);
        check({tag, "_d4"}, aux_i_d4, 32'h0);
    endtask

    // After reset, every pipeline holds zeros, so the first depth-1 outputs are zero.
    task automatic reset_model();
        exp1_q.delete();
        exp3_q.delete();
        exp4_q.delete();
        for (int i = 0; i < 2; i++) exp3_q.push_back(32'h0);
        for (int i = 0; i < 3; i++) exp4_q.push_back(32'h0);
    endtask

    task automatic drive_push(input logic [31:0] v);
        aux_in = v;
        exp1_q.push_back(v);
        exp3_q.push_back(v);
        exp4_q.push_back(v);
    endtask

    task automatic pop_check(input string tag, inout logic [31:0] q[$], input logic [31:0] obs);
        logic [31:0] exp;
        if (q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $error("FAIL %s: observed %h expected <queue empty>", tag, obs);
        end else begin
            exp = q.pop_front();
            check(tag, obs, exp);
        end
    endtask

    task automatic edge_check(input string tag);
        @(posedge sys_clk);
        #1;
        pop_check({tag, "_d1"}, exp1_q, aux_i_d1);
        pop_check({tag, "_d3"}, exp3_q, aux_i_d3);
        pop_check({tag, "_d4"}, exp4_q, aux_i_d4);
    endtask

    task automatic step(input string tag, input logic [31:0] v);
        @(negedge sys_clk);
        drive_push(v);
        edge_check(tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] pattern [4];
        pattern[0] = 32'h0000_0000;
        pattern[1] = 32'hFFFF_FFFF;
        pattern[2] = 32'hA5A5_A5A5;
        pattern[3] = 32'h5A5A_5A5A;

        // Power-up reset: outputs clear with no clock edge, then stay clear while reset is held.
        sys_rst = 1'b1;
        aux_in  = 32'hDEAD_BEEF;
        #2 sys_rst = 1'b0;
        #1 check_all_zero("por_async");
        for (int i = 0; i < 3; i++) begin
            @(negedge sys_clk);
            aux_in = $urandom;
            @(posedge sys_clk);
            #1 check_all_zero("por_hold");
        end

        @(negedge sys_clk);
        sys_rst = 1'b1;
        reset_model();
        drive_push(32'h0);
        edge_check("release");

        // Single captures.
        step("cap_35", 32'd35);
        step("cap_36", 32'd36);

        // Mid-stream reset with aux_in held at 36.
        @(negedge sys_clk);
        sys_rst = 1'b0;
        #1 check_all_zero("mid_rst_async");
        @(posedge sys_clk);
        #1 check_all_zero("mid_rst_hold");
        @(negedge sys_clk);
        sys_rst = 1'b1;
        reset_model();
        drive_push(32'd36);
        edge_check("rel_36");

        // Post-reset update, then hold.
        step("upd_40", 32'd40);
        step("hold_40", 32'd40);
        step("hold_40", 32'd40);
        step("hold_40", 32'd40);

        // Back-to-back full-width patterns, then random traffic.
        for (int i = 0; i < 4; i++) step("b2b_pat", pattern[i]);
        for (int i = 0; i < 8; i++) step("b2b_rand", $urandom);
        for (int i = 0; i < 4; i++) step("drain", 32'h0);

        // Latency step from a clean reset: 0 -> 0x12345678.
        @(negedge sys_clk);
        sys_rst = 1'b0;
        aux_in  = 32'h0;
        #1 check_all_zero("lat_rst");
        @(negedge sys_clk);
        sys_rst = 1'b1;
        reset_model();
        drive_push(32'h0);
        edge_check("lat_zero");
        step("lat_zero", 32'h0);
        for (int i = 0; i < 5; i++) step("lat_step", 32'h1234_5678);

        @(negedge sys_clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
